hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage MIPS core. Issues the write-enable,

---
 rtl/hazard_pkg.sv | 56 +++++
 rtl/hazard_sat_cnt.sv | 22 ++
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the 5-stage pipeline sequencing controller.
//   - hz_state_e  : controller state encoding (RUN=0, MEM_WAIT=1, ERR=2; 3 is illegal)
//   - HZ_*_W      : ID_EX control field widths cleared by the bubble (WB, M, EX)
//   - hz_ctrl_t   : bundle of the per-cycle pipeline register controls
//   - hz_loaduse  : load-use hazard detector
//   - hz_run_ctrl : control bundle of the free-running (RUN) state
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERR      = 2'd2
  } hz_state_e;

  localparam int HZ_WB_W        = 2;
  localparam int HZ_M_W         = 2;
  localparam int HZ_EX_W        = 4;
  localparam int HZ_IDEX_CTRL_W = HZ_WB_W + HZ_M_W + HZ_EX_W;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_bubble;
    logic exmem_we;
  } hz_ctrl_t;

  // Field order: pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we
  localparam hz_ctrl_t HZ_CTRL_FREEZE   = 6'b000000;
  localparam hz_ctrl_t HZ_CTRL_LOADUSE  = 6'b000111;
  localparam hz_ctrl_t HZ_CTRL_REDIRECT = 6'b111101;
  localparam hz_ctrl_t HZ_CTRL_FLOW     = 6'b110101;
  localparam hz_ctrl_t HZ_CTRL_ERR      = 6'b000010;
  localparam hz_ctrl_t HZ_CTRL_RESET    = 6'b001010;

  // Register 0 is hardwired, so a load to $zero never creates a dependency.
  function automatic logic hz_loaduse(input logic       mem_read,
                                      input logic [4:0] ex_rt,
                                      input logic [4:0] id_rs,
                                      input logic [4:0] id_rt);
    return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

  // A load-use stall wins over a redirect: the branch/jump operands in ID are
  // stale until the load result is forwardable.
  function automatic hz_ctrl_t hz_run_ctrl(input logic busy,
                                           input logic loaduse,
                                           input logic redirect);
    if (busy)          return HZ_CTRL_FREEZE;
    else if (loaduse)  return HZ_CTRL_LOADUSE;
    else if (redirect) return HZ_CTRL_REDIRECT;
    else               return HZ_CTRL_FLOW;
  endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// hazard_sat_cnt: saturating up-counter with synchronous clear.
//   clk_i : clock
//   clr   : synchronous clear (wins over en)
//   en    : count enable; the count holds at all-ones
//   cnt   : current count
module hazard_sat_cnt #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              clr,
  input  logic              en,
  output logic [DATA_W-1:0] cnt
);

  always_ff @(posedge clk_i) begin
    if (clr)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + DATA_W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
//   Produces PC / IF_ID / ID_EX / EX_MEM enables, the ID_EX bubble and the
//   IF_ID flush. Stalls one cycle on load-use, flushes IF_ID on a taken
//   branch or jump, freezes the pipe while data memory is busy and traps
//   into a sticky error state if the memory stays busy too long.
//
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   IDEX_MemRead_i, IDEX_RT_i        load in EX and its destination
//   IFID_RS_i, IFID_RT_i             source registers of the instruction in ID
//   branch_taken_i, jump_i           control-flow redirect from ID
//   mem_busy_i                       data memory not ready
//   PC_write_o, IFID_write_o,
//   IDEX_write_o, EXMEM_write_o      register load enables
//   IFID_flush_o, IDEX_bubble_o      NOP insertion controls
//   err_o                            sticky memory-timeout error
//   state_o                          current state (debug)
//   stall_cnt_o, flush_cnt_o         only with HAZARD_CTRL_STATS_EN defined
//
// Build option: define HAZARD_CTRL_STATS_EN to add the stall/flush statistics
// counters and their ports. Without it the controller is otherwise identical.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       IDEX_MemRead_i,
  input  logic [4:0] IDEX_RT_i,
  input  logic [4:0] IFID_RS_i,
  input  logic [4:0] IFID_RT_i,
  input  logic       branch_taken_i,
  input  logic       jump_i,
  input  logic       mem_busy_i,
  output logic       PC_write_o,
  output logic       IFID_write_o,
  output logic       IFID_flush_o,
  output logic       IDEX_write_o,
  output logic       IDEX_bubble_o,
  output logic       EXMEM_write_o,
  output logic       err_o,
  output logic [1:0] state_o
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
`endif
);

  hz_state_e        state_q;
  hz_state_e        state_nxt;
  logic             err_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_en;
  logic             wait_clr;
  logic             loaduse;
  hz_ctrl_t         ctrl;

  assign loaduse = hz_loaduse(IDEX_MemRead_i, IDEX_RT_i, IFID_RS_i, IFID_RT_i);

  // Mealy decode: the stall must gate the PC in the same cycle it is detected.
  always_comb begin
    ctrl      = hz_run_ctrl(mem_busy_i, loaduse, branch_taken_i | jump_i);
    state_nxt = state_q;
    wait_en   = 1'b0;
    wait_clr  = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (mem_busy_i) begin
          state_nxt = HZ_MEM_WAIT;
          wait_en   = 1'b1;  // counter is zero in RUN, so it lands on 1
        end
      end
      HZ_MEM_WAIT: begin
        // On release the frozen ID/EX contents are re-judged as in RUN,
        // so a pending branch or load-use is acted on this cycle.
        if (!mem_busy_i) begin
          state_nxt = HZ_RUN;
          wait_clr  = 1'b1;
        end else if (wait_cnt == CNT_W'(WAIT_LIMIT)) begin
          state_nxt = HZ_ERR;
        end else begin
          wait_en = 1'b1;
        end
      end
      HZ_ERR: begin
        ctrl = HZ_CTRL_ERR;
      end
      default: begin
        state_nxt = HZ_RUN;
        wait_clr  = 1'b1;
      end
    endcase
    if (rst_i) begin
      ctrl      = HZ_CTRL_RESET;
      state_nxt = HZ_RUN;
      wait_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    state_q <= state_nxt;
    if (rst_i)
      err_q <= 1'b0;
    else if (state_nxt == HZ_ERR)
      err_q <= 1'b1;
  end

  hazard_sat_cnt #(
    .DATA_W (CNT_W)
  ) u_wait_cnt (
    .clk_i (clk_i),
    .clr   (wait_clr),
    .en    (wait_en),
    .cnt   (wait_cnt)
  );

`ifdef HAZARD_CTRL_STATS_EN
  hazard_sat_cnt #(
    .DATA_W (16)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .en    (!ctrl.pc_we),
    .cnt   (stall_cnt_o)
  );

  hazard_sat_cnt #(
    .DATA_W (16)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .en    (ctrl.ifid_flush),
    .cnt   (flush_cnt_o)
  );
`endif

  assign PC_write_o    = ctrl.pc_we;
  assign IFID_write_o  = ctrl.ifid_we;
  assign IFID_flush_o  = ctrl.ifid_flush;
  assign IDEX_write_o  = ctrl.idex_we;
  assign IDEX_bubble_o = ctrl.idex_bubble;
  assign EXMEM_write_o = ctrl.exmem_we;
  assign err_o         = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int WAIT_LIMIT = 15;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       IDEX_MemRead_i = 1'b0;
  logic [4:0] IDEX_RT_i = '0;
  logic [4:0] IFID_RS_i = '0;
  logic [4:0] IFID_RT_i = '0;
  logic       branch_taken_i = 1'b0;
  logic       jump_i = 1'b0;
  logic       mem_busy_i = 1'b0;
  logic       PC_write_o, IFID_write_o, IFID_flush_o;
  logic       IDEX_write_o, IDEX_bubble_o, EXMEM_write_o;
  logic       err_o;
  logic [1:0] state_o;
`ifdef HAZARD_CTRL_STATS_EN
  logic [15:0] stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (8)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RT_i      (IDEX_RT_i),
    .IFID_RS_i      (IFID_RS_i),
    .IFID_RT_i      (IFID_RT_i),
    .branch_taken_i (branch_taken_i),
    .jump_i         (jump_i),
    .mem_busy_i     (mem_busy_i),
    .PC_write_o     (PC_write_o),
    .IFID_write_o   (IFID_write_o),
    .IFID_flush_o   (IFID_flush_o),
    .IDEX_write_o   (IDEX_write_o),
    .IDEX_bubble_o  (IDEX_bubble_o),
    .EXMEM_write_o  (EXMEM_write_o),
    .err_o          (err_o),
    .state_o        (state_o)
`ifdef HAZARD_CTRL_STATS_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: how many busy cycles in a row the pipe has seen, and
  // whether the timeout has tripped.
  int busy_streak = 0;
  bit trapped     = 1'b0;
  int m_stall     = 0;
  int m_flush     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, check the combinational response mid-cycle,
  // then advance the model across the clock edge.
  task automatic step(input logic r, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic br, input logic jp, input logic busy);
    logic [5:0] e;  // {PC, IFID, flush, IDEX, bubble, EXMEM}
    logic [1:0] es;
    bit         lu;
    rst_i = r; IDEX_MemRead_i = mr; IDEX_RT_i = ert; IFID_RS_i = rs;
    IFID_RT_i = rt; branch_taken_i = br; jump_i = jp; mem_busy_i = busy;
    @(negedge clk_i);
    lu = mr && (ert != 0) && (ert == rs || ert == rt);
    if (r)             e = 6'b001010;
    else if (trapped)  e = 6'b000010;
    else if (busy)     e = 6'b000000;
    else if (lu)       e = 6'b000111;
    else if (br || jp) e = 6'b111101;
    else               e = 6'b110101;
    es = trapped ? 2'd2 : (busy_streak > 0 ? 2'd1 : 2'd0);
    chk("ctrl", {26'd0, PC_write_o, IFID_write_o, IFID_flush_o,
                 IDEX_write_o, IDEX_bubble_o, EXMEM_write_o}, {26'd0, e});
    chk("state", {30'd0, state_o}, {30'd0, es});
    chk("err", {31'd0, err_o}, {31'd0, trapped});
`ifdef HAZARD_CTRL_STATS_EN
    chk("stall_cnt", {16'd0, stall_cnt_o}, m_stall);
    chk("flush_cnt", {16'd0, flush_cnt_o}, m_flush);
`endif
    if (r) begin
      busy_streak = 0; trapped = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[5] && m_stall < 16'hFFFF) m_stall++;
      if (e[3] && m_flush < 16'hFFFF) m_flush++;
      if (!trapped) begin
        if (busy) begin
          busy_streak++;
          if (busy_streak > WAIT_LIMIT) trapped = 1'b1;
        end else begin
          busy_streak = 0;
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int burst;
  logic r, busy;

  initial begin
    // reset held for two cycles, then free flow
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // load-use on rs, then on rt, then to $zero (no stall)
    step(0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0);
    idle();
    step(0, 1, 5'd9, 5'd2, 5'd9, 0, 0, 0);
    step(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd8, 5'd8, 5'd8, 0, 0, 0);
    // branch, jump, branch under load-use
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 5'd4, 5'd4, 5'd1, 1, 0, 0);
    // single busy cycle, then three busy cycles with a pending branch
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("mem_wait_no_err", {31'd0, err_o}, 32'd0);
    // exactly WAIT_LIMIT busy cycles are tolerated
    for (int i = 0; i < WAIT_LIMIT; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 5'd6, 5'd6, 5'd0, 0, 0, 0);
    // reset in the middle of a wait
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle();
    // timeout: 20 busy cycles, then sticky after release
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("err_sticky", {31'd0, err_o}, 32'd1);
    chk("err_state", {30'd0, state_o}, 32'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("err_cleared", {31'd0, err_o}, 32'd0);
    // randomized traffic with occasional long busy bursts and resets
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 79) == 0);
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(1, 20);
      if (burst > 0) begin
        busy = 1'b1;
        burst--;
      end else begin
        busy = ($urandom_range(0, 7) == 0);
      end
      step(r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), busy);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
